// File: rtl/dkong_rom_loader.sv
// Purpose: decodes the HPS ioctl byte stream into ROM region write strobes and owns the core reset.
// Latency: one cycle from ioctl_wr to rom_we/rom_addr/rom_data; core_reset releases HOLD_CYCLES+1 cycles after a download or user reset ends.
// Backpressure: none; every in-range byte seen during a download is forwarded, one per cycle.
module dkong_rom_loader #(
    parameter logic [15:0] CPU_SIZE    = 16'h4000,
    parameter logic [15:0] SND_SIZE    = 16'h1000,
    parameter logic [15:0] TILE_SIZE   = 16'h1000,
    parameter logic [15:0] SPR_SIZE    = 16'h2000,
    parameter logic [15:0] PROM_SIZE   = 16'h0300,
    parameter int          HOLD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic [4:0]  rom_we,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [16:0] byte_count
);

    // Cumulative region bases; the image is laid out CPU, sound, tiles, sprites, PROM.
    localparam logic [16:0] BASE1 = {1'b0, CPU_SIZE};
    localparam logic [16:0] BASE2 = BASE1 + {1'b0, SND_SIZE};
    localparam logic [16:0] BASE3 = BASE2 + {1'b0, TILE_SIZE};
    localparam logic [16:0] BASE4 = BASE3 + {1'b0, SPR_SIZE};
    localparam logic [16:0] TOTAL = BASE4 + {1'b0, PROM_SIZE};

    localparam int          CW       = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] settle_cnt;
    logic          prev_download;
    logic          prev_user_reset;

    logic          dl_rise;
    logic          dl_fall;
    logic          ur_fall;
    logic          in_range;
    logic          wr_window;
    logic          take;
    logic          bad;
    logic [4:0]    we_dec;
    logic [24:0]   base_sel;
    logic [15:0]   rom_off;
    logic [16:0]   count_base;
    logic [16:0]   count_next;
    logic          err_next;
    logic          err_final;

    assign dl_rise = ioctl_download & ~prev_download;
    assign dl_fall = ~ioctl_download & prev_download;
    assign ur_fall = ~user_reset & prev_user_reset;

    // Region decode, acceptance of the current byte and the updated count/error it implies.
    always_comb begin
        we_dec    = 5'b00000;
        base_sel  = 25'd0;
        in_range  = (ioctl_addr < {8'd0, TOTAL});
        if (ioctl_addr < {8'd0, BASE1}) begin
            we_dec   = 5'b00001;
            base_sel = 25'd0;
        end else if (ioctl_addr < {8'd0, BASE2}) begin
            we_dec   = 5'b00010;
            base_sel = {8'd0, BASE1};
        end else if (ioctl_addr < {8'd0, BASE3}) begin
            we_dec   = 5'b00100;
            base_sel = {8'd0, BASE2};
        end else if (ioctl_addr < {8'd0, BASE4}) begin
            we_dec   = 5'b01000;
            base_sel = {8'd0, BASE3};
        end else begin
            we_dec   = 5'b10000;
            base_sel = {8'd0, BASE4};
        end
        rom_off = 16'(ioctl_addr - base_sel);

        // A write on the same cycle the download starts belongs to the new download.
        wr_window  = (state == S_LOAD) || dl_rise;
        take       = ioctl_wr & wr_window & in_range;
        bad        = ioctl_wr & wr_window & ~in_range;

        count_base = (state == S_LOAD) ? byte_count : 17'd0;
        count_next = count_base;
        if (take && (count_base != 17'h1FFFF)) begin
            count_next = count_base + 17'd1;
        end
        err_next  = ((state == S_LOAD) ? load_error : 1'b0) | bad;
        // The length check at download end sees the byte accepted on that same cycle.
        err_final = err_next | (count_next != TOTAL);
    end

    // Sequencer: download tracking, settle timer, core reset and the registered write port.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state           <= S_IDLE;
            settle_cnt      <= '0;
            // Seed the edge detectors with the live inputs so a download already in
            // progress is not mistaken for a fresh one once reset releases.
            prev_download   <= ioctl_download;
            prev_user_reset <= user_reset;
            rom_we          <= 5'b00000;
            rom_addr        <= 16'd0;
            rom_data        <= 8'd0;
            core_reset      <= 1'b1;
            load_done       <= 1'b0;
            load_error      <= 1'b0;
            byte_count      <= 17'd0;
        end else begin
            prev_download   <= ioctl_download;
            prev_user_reset <= user_reset;
            rom_we          <= take ? we_dec : 5'b00000;
            if (take) begin
                rom_addr <= rom_off;
                rom_data <= ioctl_dout;
            end

            if (dl_rise && (state != S_LOAD)) begin
                state      <= S_LOAD;
                settle_cnt <= '0;
                core_reset <= 1'b1;
                load_done  <= 1'b0;
                load_error <= err_next;
                byte_count <= count_next;
            end else begin
                case (state)
                    S_IDLE: begin
                        core_reset <= 1'b1;
                    end
                    S_LOAD: begin
                        core_reset <= 1'b1;
                        byte_count <= count_next;
                        if (dl_fall) begin
                            state      <= S_SETTLE;
                            settle_cnt <= '0;
                            load_error <= err_final;
                            load_done  <= ~err_final;
                        end else begin
                            load_error <= err_next;
                        end
                    end
                    S_SETTLE: begin
                        core_reset <= 1'b1;
                        if (settle_cnt == CNT_LAST) begin
                            settle_cnt <= '0;
                            state      <= load_done ? S_RUN : S_IDLE;
                        end else begin
                            settle_cnt <= settle_cnt + CW'(1);
                        end
                    end
                    S_RUN: begin
                        if (ur_fall) begin
                            state      <= S_SETTLE;
                            settle_cnt <= '0;
                            core_reset <= 1'b1;
                        end else begin
                            core_reset <= user_reset;
                        end
                    end
                    default: begin
                        state      <= S_IDLE;
                        core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dkong_rom_loader.md
# dkong_rom_loader

Sequences ROM download and core reset for the Donkey Kong core. Takes the HPS ioctl byte stream and decodes each address into a one-hot write strobe for the five ROM/PROM regions, with a region-relative address. Owns the core reset: holds the core in reset from power-up until a complete download, during any later download, and for a fixed settle period afterwards. Sits between `hps_io` and `dkong_top` in `emu`, and replaces the direct `ioctl_*` hookup and the ad-hoc reset OR.

## Interface
Parameters:
- `CPU_SIZE`, 16'h4000: main CPU ROM bytes; region 0 starts at 0.
- `SND_SIZE`, 16'h1000: sound CPU ROM bytes; region 1.
- `TILE_SIZE`, 16'h1000: tile gfx ROM bytes; region 2.
- `SPR_SIZE`, 16'h2000: sprite gfx ROM bytes; region 3.
- `PROM_SIZE`, 16'h0300: colour PROM bytes; region 4.
- `HOLD_CYCLES`, 1024: settle cycles after download end or after a user reset release; must be ≥ 2.

Total length `TOTAL` = sum of the five sizes = 0x8300 with defaults. Region bases are cumulative sums.

Ports:
- `clk_sys`  in  1  system clock; all logic sits on its rising edge.
- `reset`  in  1  synchronous, active-high; returns the block to IDLE.
- `ioctl_download`  in  1  high for the whole download.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `user_reset`  in  1  status/button reset request, level.
- `rom_we`  out  5  one-hot region write strobe; bit i = region i.
- `rom_addr`  out  16  address relative to the region base.
- `rom_data`  out  8  registered copy of `ioctl_dout`.
- `core_reset`  out  1  active-high reset to `dkong_top`.
- `load_done`  out  1  at least one complete, error-free download has finished.
- `load_error`  out  1  the last download was out of range or the wrong length.
- `byte_count`  out  17  accepted bytes in the current or last download.

## Operation
- States: IDLE, LOAD, SETTLE, RUN.
- IDLE (after `reset`): `core_reset`=1.
  - Rising edge of `ioctl_download` → LOAD.
- LOAD: `core_reset`=1.
  - On entry: clear `byte_count` and `load_error`, and clear `load_done`.
  - Each `ioctl_wr`:
    - If `ioctl_addr` < TOTAL: decode the region by comparing against the cumulative bases. Set exactly one `rom_we` bit. Set `rom_addr` = `ioctl_addr` − base (low 16 bits) and `rom_data` = `ioctl_dout`. Increment `byte_count`, saturating at 17'h1FFFF.
    - If `ioctl_addr` ≥ TOTAL: no strobe, set `load_error`=1, and do not count the byte.
  - Falling edge of `ioctl_download` → SETTLE.
    - `load_error` also becomes 1 if `byte_count` != TOTAL.
    - `load_done` becomes 1 only if `load_error` is 0.
- SETTLE: `core_reset`=1. A counter runs from 0 to HOLD_CYCLES−1, then → RUN if `load_done`, otherwise → IDLE.
- RUN: `core_reset` = `user_reset`.
  - Falling edge of `user_reset` → SETTLE, counter restarted.
  - Rising edge of `ioctl_download` → LOAD.
- `ioctl_wr` is ignored outside LOAD; `rom_we` stays 0.
- A rising edge of `ioctl_download` in any state other than LOAD goes to LOAD, which aborts SETTLE.
- Edge detection uses a registered previous copy of `ioctl_download` and `user_reset`. Both signals are already in `clk_sys`, so no synchronizer is needed.

## Timing
- Reset values:
  - `rom_we`=0, `rom_addr`=0, `rom_data`=0.
  - `core_reset`=1.
  - `load_done`=0, `load_error`=0, `byte_count`=0.
  - State IDLE, counters 0.
- Write latency: `ioctl_wr` at cycle N gives `rom_we`, `rom_addr` and `rom_data` at N+1. `rom_we` is high for exactly one cycle.
- Back-to-back `ioctl_wr` on consecutive cycles is supported, one strobe per cycle with no loss.
- Download start and the last write on the same cycle: the write is processed as in LOAD.
- Download end and `ioctl_wr` on the same cycle: the write is accepted and counted before the length check. The check uses the updated count.
- `core_reset` is registered:
  - It deasserts exactly HOLD_CYCLES+1 cycles after the falling edge of `ioctl_download` (or of `user_reset`) is sampled.
  - It asserts one cycle after a rising edge of `ioctl_download` or `user_reset`.
- `reset` mid-LOAD: the next cycle shows all reset values. Later writes are ignored until a new `ioctl_download` rising edge.
- `user_reset` during LOAD or SETTLE has no effect on the state. If it is still high on entry to RUN, `core_reset` stays 1 until it falls, followed by HOLD_CYCLES of settle.

## Test plan
- Full download: stream 0x8300 bytes at addresses 0..0x82FF, then drop `ioctl_download` → 0x4000 strobes on `rom_we[0]`, 0x1000 on [1], 0x1000 on [2], 0x2000 on [3], 0x300 on [4]. `load_done`=1, `load_error`=0, `core_reset` falls HOLD_CYCLES+1 cycles after the end.
- Boundary decode: writes at 0x3FFF, 0x4000, 0x4FFF, 0x5000, 0x82FF → (`rom_we`, `rom_addr`) = (00001, 0x3FFF), (00010, 0), (00010, 0xFFF), (00100, 0), (10000, 0x2FF).
- Short download: 0x8000 bytes only → `load_error`=1, `load_done`=0, state returns to IDLE, `core_reset` stays 1.
- Out-of-range: a write at 0x9000 inside an otherwise complete download → no `rom_we` pulse, `load_error`=1, `byte_count`=0x8300.
- User reset in RUN: `user_reset` held high for 10 cycles → `core_reset` high from the cycle after the rise until HOLD_CYCLES+1 cycles after the fall. `load_done` stays 1.
- `reset` mid-LOAD after 100 bytes → all outputs return to reset values the next cycle. Further `ioctl_wr` gives no strobes. A new download then proceeds normally.
